kfpga_config_loader: RTL and testbench
======================================

Name: kfpga_config_loader

Overview:
- Upstream feeder for the fabric core's serial configuration chain.
- Accepts bitstream words over a valid/ready interface and serialises them LSB-first onto the core's config_in, qualified by config_enable.
- Drives the core's config_nreset clear pulse before loading, counts exactly CHAIN_LENGTH bits, then reports done.
- Sits between the host/bus bitstream source and the core's config_* ports.

Parameters:
- WORD_WIDTH, 32, width of incoming bitstream words.
- CHAIN_LENGTH, 4096, total configuration bits in the core chain (>=1).
- CLEAR_CYCLES, 4, cycles config_nreset is held low before loading (>=1).
- COUNT_WIDTH, 16, width of the internal bit counter; must satisfy 2^COUNT_WIDTH > CHAIN_LENGTH.

Ports:
- clock  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle request to begin a load; ignored unless IDLE.
- word_in  in  WORD_WIDTH  bitstream word; bit 0 is shifted first.
- word_valid  in  1  word_in is valid.
- word_ready  out  1  loader accepts word this cycle (transfer = valid && ready).
- config_out  out  1  serial bit to the core's config_in.
- config_enable  out  1  to the core's config_enable; high only in cycles where config_out carries a real bit.
- config_nreset  out  1  to the core's config_nreset; low during CLEAR.
- busy  out  1  high in CLEAR, LOAD and CHECK.
- done  out  1  sticky; high after successful completion until next accepted start or reset.
- error  out  1  sticky; high after CRC mismatch (feature only; else constant 0).

Behaviour:
- Clock is clock; reset is synchronous and active-high. With reset high at a rising edge: state IDLE, word_ready=0, config_out=0, config_enable=0, config_nreset=1, busy=0, done=0, error=0, counters cleared.
- Reset mid-operation aborts at that edge. The partially loaded chain is left as is; no clear pulse is issued until the next start.
- States: IDLE, CLEAR, LOAD, CHECK (feature only), DONE.
- IDLE: start=1 moves to CLEAR next cycle and clears done/error.
- CLEAR: config_nreset=0 for exactly CLEAR_CYCLES cycles, then LOAD. word_ready=0.
- LOAD: internal shift register holds the current word plus a bits-remaining count.
  - word_ready=1 when bits-remaining is 0 or 1 (empty, or shifting its last bit). This gives gapless back-to-back streaming.
  - A word accepted in cycle N has its bit 0 on config_out with config_enable=1 in cycle N+1, bit k in cycle N+1+k.
  - If no word is available when the register empties, config_enable=0 and config_out=0 (the core chain holds) until a word arrives.
- The global bit counter increments on each config_enable=1 cycle. The cycle carrying bit CHAIN_LENGTH-1 is the last shifted bit.
- Partial last word: if CHAIN_LENGTH mod WORD_WIDTH != 0, only the low (CHAIN_LENGTH mod WORD_WIDTH) bits of the final word are shifted. Upper bits are discarded, not shifted, with config_enable=0.
- word_ready is never asserted for a word beyond the chain; after the final word is accepted, word_ready=0.
- After the last bit: go to DONE (or CHECK with feature). In DONE: busy=0, done=1, then IDLE behaviour applies. DONE is equivalent to IDLE with done set.
- start while busy is ignored. word_valid outside LOAD is ignored (word_ready=0).
- config_out and config_enable are registered outputs.

Optional Feature:
- Macro: KFPGA_CONFIG_CRC_EN.
- Defined:
  - A CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection, no final XOR) is updated with each shifted bit in shift order.
  - After the last chain bit, the state goes to CHECK with word_ready=1, and exactly one extra word is accepted. Its bits [15:0] are the expected CRC.
  - Match: DONE with done=1. Mismatch: DONE with error=1 and done=0.
  - The CRC word is never shifted to config_out.
- Undefined: no CHECK state, error tied 0, no extra word consumed.

Test Plan:
- Params W=32, L=40, CLEAR=4. start, then words 0xA5A5A5A5 and 0x000000C3 presented continuously:
  - config_nreset low 4 cycles.
  - 40 consecutive config_enable cycles emitting 1,0,1,0,0,1,0,1... then bits 1,1,0,0,0,0,1,1.
  - done=1 the cycle after the 40th bit; word_ready never high for a third word.
- Same run with word_valid dropped for 5 cycles after the first word: config_enable low exactly 5 cycles, bit order unchanged, total 40 enabled bits.
- start asserted during LOAD: no effect on counters or outputs; second start after done restarts with a fresh 4-cycle clear, done dropped.
- Reset asserted on the 20th shifted bit: next cycle all outputs at reset values, state IDLE, word_ready=0.
- L=64, W=32 back-to-back words: word_ready high on the cycle of bit 31, 64 contiguous config_enable cycles with no gap.
- With KFPGA_CONFIG_CRC_EN, L=32, data 0x00000000:
  - Correct CRC word gives done=1, error=0.
  - CRC word XOR 0x0001 gives error=1, done=0.
  - The CRC word never appears on config_out.

Source files
------------

// File: rtl/kfpga_config_loader.sv
// kfpga_config_loader: streams bitstream words LSB-first into the fabric configuration chain.
// Optional CRC-16-CCITT trailer check enabled by defining KFPGA_CONFIG_CRC_EN.
`timescale 1ns/1ps
module kfpga_config_loader #(
    parameter int WORD_WIDTH   = 32,
    parameter int CHAIN_LENGTH = 4096,
    parameter int CLEAR_CYCLES = 4,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WORD_WIDTH-1:0] word_in,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  config_out,
    output logic                  config_enable,
    output logic                  config_nreset,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);
    localparam int NUM_WORDS = (CHAIN_LENGTH + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int LAST_BITS = CHAIN_LENGTH - (NUM_WORDS - 1) * WORD_WIDTH;
    localparam int RW        = $clog2(WORD_WIDTH + 1);
    localparam int CW        = $clog2(CLEAR_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, CHECK, DONE} state_t;

    state_t                 state;
    logic [WORD_WIDTH-1:0]  shreg;
    logic [RW-1:0]          rem;
    logic [COUNT_WIDTH-1:0] bit_cnt;
    logic [COUNT_WIDTH-1:0] word_cnt;
    logic [CW-1:0]          clr_cnt;
    logic                   take;
    logic                   last_bit;
`ifdef KFPGA_CONFIG_CRC_EN
    logic [15:0]            crc;
`endif

    // rem counts the bit currently on config_out plus those still queued behind it
`ifdef KFPGA_CONFIG_CRC_EN
    assign word_ready = (state == LOAD && rem <= RW'(1) && word_cnt < COUNT_WIDTH'(NUM_WORDS)) || state == CHECK;
`else
    assign word_ready = state == LOAD && rem <= RW'(1) && word_cnt < COUNT_WIDTH'(NUM_WORDS);
`endif
    assign take     = word_valid && word_ready;
    assign last_bit = state == LOAD && config_enable && bit_cnt == COUNT_WIDTH'(CHAIN_LENGTH - 1);
    assign busy     = state == CLEAR || state == LOAD || state == CHECK;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            config_out    <= 1'b0;
            config_enable <= 1'b0;
            config_nreset <= 1'b1;
            done          <= 1'b0;
            error         <= 1'b0;
            shreg         <= '0;
            rem           <= '0;
            bit_cnt       <= '0;
            word_cnt      <= '0;
            clr_cnt       <= '0;
`ifdef KFPGA_CONFIG_CRC_EN
            crc           <= 16'hFFFF;
`endif
        end else begin
            case (state)
                IDLE, DONE: if (start) begin
                    state         <= CLEAR;
                    config_nreset <= 1'b0;
                    clr_cnt       <= CW'(CLEAR_CYCLES - 1);
                    done          <= 1'b0;
                    error         <= 1'b0;
                    bit_cnt       <= '0;
                    word_cnt      <= '0;
                    rem           <= '0;
`ifdef KFPGA_CONFIG_CRC_EN
                    crc           <= 16'hFFFF;
`endif
                end
                CLEAR: if (clr_cnt == '0) begin
                    state         <= LOAD;
                    config_nreset <= 1'b1;
                end else begin
                    clr_cnt <= clr_cnt - CW'(1);
                end
                LOAD: begin
                    if (config_enable) begin
                        bit_cnt <= bit_cnt + COUNT_WIDTH'(1);
`ifdef KFPGA_CONFIG_CRC_EN
                        crc <= {crc[14:0], 1'b0} ^ ({16{crc[15] ^ config_out}} & 16'h1021);
`endif
                    end
                    // the final word only feeds its low LAST_BITS bits into the chain
                    if (take) begin
                        config_out    <= word_in[0];
                        config_enable <= 1'b1;
                        shreg         <= word_in >> 1;
                        rem           <= word_cnt == COUNT_WIDTH'(NUM_WORDS - 1) ? RW'(LAST_BITS) : RW'(WORD_WIDTH);
                        word_cnt      <= word_cnt + COUNT_WIDTH'(1);
                    end else if (rem > RW'(1)) begin
                        config_out <= shreg[0];
                        shreg      <= shreg >> 1;
                        rem        <= rem - RW'(1);
                    end else begin
                        config_out    <= 1'b0;
                        config_enable <= 1'b0;
                        rem           <= '0;
                    end
                    if (last_bit) begin
`ifdef KFPGA_CONFIG_CRC_EN
                        state <= CHECK;
`else
                        state <= DONE;
                        done  <= 1'b1;
`endif
                    end
                end
`ifdef KFPGA_CONFIG_CRC_EN
                CHECK: if (take) begin
                    state <= DONE;
                    done  <= word_in[15:0] == crc;
                    error <= word_in[15:0] != crc;
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_kfpga_config_loader.sv
// tb_kfpga_config_loader: directed bench for the configuration loader (L=40, L=64, and L=32 with CRC).
`timescale 1ns/1ps
module tb_kfpga_config_loader;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    logic a_start = 0, a_valid = 0, a_ready, a_out, a_en, a_nrst, a_busy, a_done, a_err;
    logic [31:0] a_word = '0;
    logic b_start = 0, b_valid = 0, b_ready, b_out, b_en, b_nrst, b_busy, b_done, b_err;
    logic [31:0] b_word = '0;
    logic c_start = 0, c_valid = 0, c_ready, c_out, c_en, c_nrst, c_busy, c_done, c_err;
    logic [31:0] c_word = '0;

    kfpga_config_loader #(.WORD_WIDTH(32), .CHAIN_LENGTH(40), .CLEAR_CYCLES(4)) dut_a (
        .clock(clock), .reset(reset), .start(a_start), .word_in(a_word), .word_valid(a_valid),
        .word_ready(a_ready), .config_out(a_out), .config_enable(a_en), .config_nreset(a_nrst),
        .busy(a_busy), .done(a_done), .error(a_err));
    kfpga_config_loader #(.WORD_WIDTH(32), .CHAIN_LENGTH(64), .CLEAR_CYCLES(4)) dut_b (
        .clock(clock), .reset(reset), .start(b_start), .word_in(b_word), .word_valid(b_valid),
        .word_ready(b_ready), .config_out(b_out), .config_enable(b_en), .config_nreset(b_nrst),
        .busy(b_busy), .done(b_done), .error(b_err));
    kfpga_config_loader #(.WORD_WIDTH(32), .CHAIN_LENGTH(32), .CLEAR_CYCLES(4)) dut_c (
        .clock(clock), .reset(reset), .start(c_start), .word_in(c_word), .word_valid(c_valid),
        .word_ready(c_ready), .config_out(c_out), .config_enable(c_en), .config_nreset(c_nrst),
        .busy(c_busy), .done(c_done), .error(c_err));

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [15:0] crc_model(input logic [31:0] d, input int n);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < n; i++)
            c = {c[14:0], 1'b0} ^ ((c[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return c;
    endfunction

    task automatic test_reset;
        logic [6:0] got;
        reset = 1'b1;
        tick;
        tick;
        got = {a_ready, a_out, a_en, a_nrst, a_busy, a_done, a_err};
        checks++;
        if (got !== 7'b0001000) begin
            errors++;
            $display("FAIL reset_values got %b want 0001000", got);
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic run_a(input bit gap, input bit mid_start);
        logic [39:0] exp_bits = 40'hC3_A5A5A5A5;
        int lowc = 0, nb = 0, widx = 0, hold = 0, gapc = 0;
        bit third = 0, seen_done = 0, was_last = 0;
        a_start = 1;
        tick;
        a_start = 0;
        checks++;
        if (a_done !== 1'b0 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL start_accept got done=%b busy=%b want done=0 busy=1", a_done, a_busy);
        end
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (a_done === 1'b1) begin
                seen_done = 1;
                break;
            end
            was_last = 0;
            if (a_nrst === 1'b0) lowc++;
            if (a_en === 1'b1) begin
                checks++;
                if (nb >= 40 || a_out !== exp_bits[nb]) begin
                    errors++;
                    $display("FAIL bit_%0d got %b want %b", nb, a_out, nb < 40 ? exp_bits[nb] : 1'bx);
                end
                nb++;
                was_last = nb == 40;
            end else if (nb > 0 && nb < 40) gapc++;
            a_start = mid_start && nb == 10;
            if (widx == 2 && a_ready === 1'b1) third = 1;
            a_valid = widx < 2 && !(gap && widx == 1 && a_ready === 1'b1 && hold < 5);
            if (gap && widx == 1 && a_ready === 1'b1 && !a_valid) hold++;
            a_word = widx == 0 ? 32'hA5A5A5A5 : 32'h000000C3;
            if (a_valid && a_ready === 1'b1) widx++;
            tick;
        end
        a_valid = 0;
        a_start = 0;
        checks++;
        if (!seen_done || !was_last) begin
            errors++;
            $display("FAIL done_timing got seen=%0d after_last=%0d want 1 1", seen_done, was_last);
        end
        checks++;
        if (nb != 40) begin
            errors++;
            $display("FAIL bit_count got %0d want 40", nb);
        end
        checks++;
        if (lowc != 4) begin
            errors++;
            $display("FAIL clear_cycles got %0d want 4", lowc);
        end
        checks++;
        if (gapc != (gap ? 5 : 0)) begin
            errors++;
            $display("FAIL enable_gap got %0d want %0d", gapc, gap ? 5 : 0);
        end
        checks++;
        if (third) begin
            errors++;
            $display("FAIL third_word_ready got 1 want 0");
        end
        checks++;
        if (a_busy !== 1'b0 || a_err !== 1'b0 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL done_state got busy=%b err=%b ready=%b want 0 0 0", a_busy, a_err, a_ready);
        end
        tick;
    endtask

    task automatic test_stream;
        run_a(0, 0);
    endtask

    task automatic test_gap_and_start;
        run_a(1, 1);
        run_a(0, 0);
    endtask

    task automatic test_reset_mid_load;
        int nb = 0, widx = 0;
        bit hit = 0;
        a_start = 1;
        tick;
        a_start = 0;
        for (int cyc = 0; cyc < 200 && !hit; cyc++) begin
            if (a_en === 1'b1) begin
                nb++;
                if (nb == 20) hit = 1;
            end
            a_valid = widx < 2;
            a_word = widx == 0 ? 32'hA5A5A5A5 : 32'h000000C3;
            if (hit) reset = 1'b1;
            else if (a_valid && a_ready === 1'b1) widx++;
            tick;
        end
        reset = 1'b0;
        a_valid = 1'b1;
        checks++;
        if (!hit || {a_ready, a_out, a_en, a_nrst, a_busy, a_done, a_err} !== 7'b0001000) begin
            errors++;
            $display("FAIL reset_mid_load got hit=%0d %b want 1 0001000", hit,
                     {a_ready, a_out, a_en, a_nrst, a_busy, a_done, a_err});
        end
        tick;
        tick;
        checks++;
        if (a_nrst !== 1'b1 || a_busy !== 1'b0 || a_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got nrst=%b busy=%b ready=%b want 1 0 0", a_nrst, a_busy, a_ready);
        end
        a_valid = 1'b0;
    endtask

    task automatic test_back_to_back;
        logic [63:0] exp_bits = 64'h9ABCDEF0_12345678;
        int nb = 0, widx = 0, gapc = 0;
        bit rdy31 = 0;
        b_start = 1;
        tick;
        b_start = 0;
        for (int cyc = 0; cyc < 300 && b_done !== 1'b1; cyc++) begin
            if (b_en === 1'b1) begin
                if (nb == 31) rdy31 = b_ready === 1'b1;
                checks++;
                if (nb >= 64 || b_out !== exp_bits[nb]) begin
                    errors++;
                    $display("FAIL b2b_bit_%0d got %b", nb, b_out);
                end
                nb++;
            end else if (nb > 0 && nb < 64) gapc++;
            b_valid = widx < 2;
            b_word = widx == 0 ? 32'h12345678 : 32'h9ABCDEF0;
            if (b_valid && b_ready === 1'b1) widx++;
            tick;
        end
        b_valid = 0;
        checks++;
        if (!rdy31) begin
            errors++;
            $display("FAIL ready_on_bit31 got 0 want 1");
        end
        checks++;
        if (nb != 64 || gapc != 0 || b_done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_stream got bits=%0d gaps=%0d done=%b want 64 0 1", nb, gapc, b_done);
        end
        tick;
    endtask

    task automatic test_crc(input bit bad);
        logic [15:0] exp_crc = crc_model(32'h0, 32);
        int nb = 0, widx = 0;
        c_start = 1;
        tick;
        c_start = 0;
        for (int cyc = 0; cyc < 300 && c_done !== 1'b1 && c_err !== 1'b1; cyc++) begin
            if (c_en === 1'b1) begin
                checks++;
                if (nb >= 32 || c_out !== 1'b0) begin
                    errors++;
                    $display("FAIL crc_bit_%0d got %b want 0 within 32 bits", nb, c_out);
                end
                nb++;
            end
            c_valid = widx < 2;
            c_word = widx == 0 ? 32'h0 : {16'h0, exp_crc ^ {15'h0, bad}};
            if (c_valid && c_ready === 1'b1) widx++;
            tick;
        end
        c_valid = 0;
        checks++;
        if (nb != 32 || widx != 2 || c_done !== !bad || c_err !== bad || c_busy !== 1'b0) begin
            errors++;
            $display("FAIL crc_result got bits=%0d words=%0d done=%b err=%b want 32 2 %b %b",
                     nb, widx, c_done, c_err, !bad, bad);
        end
        tick;
    endtask

    initial begin
        test_reset;
`ifdef KFPGA_CONFIG_CRC_EN
        test_crc(0);
        test_crc(1);
        test_crc(0);
`else
        test_stream;
        test_gap_and_start;
        test_back_to_back;
`endif
        test_reset_mid_load;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
